// File: rtl/scr1_copier_pkg.sv
// scr1_copier_pkg: memory-interface types, copier FSM states, error codes and constants
// Contents: SCR1 data-memory widths and cmd/width/resp encodings, copier state and error enums, word stride.
package scr1_copier_pkg;

    localparam int SCR1_DMEM_AWIDTH        = 32;
    localparam int SCR1_DMEM_DWIDTH        = 32;
    localparam int SCR1_COPIER_WORD_STRIDE = 4;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [2:0] {
        SCR1_COPIER_IDLE,
        SCR1_COPIER_RD_REQ,
        SCR1_COPIER_RD_WAIT,
        SCR1_COPIER_WR_REQ,
        SCR1_COPIER_WR_WAIT
    } type_scr1_copier_state_e;

    typedef enum logic [1:0] {
        SCR1_COPIER_ERR_NONE     = 2'd0,
        SCR1_COPIER_ERR_BUSERR   = 2'd1,
        SCR1_COPIER_ERR_TIMEOUT  = 2'd2,
        SCR1_COPIER_ERR_MISALIGN = 2'd3
    } type_scr1_copier_err_e;

endpackage

// File: rtl/scr1_copier_tmo.sv
// scr1_copier_tmo: clearable saturating wait counter with expiry flag
// Ports: clk, rst (async, active-high); clr zeroes the count; inc counts one waiting cycle;
//        expired is high in the inc cycle that completes LIMIT waiting cycles.
module scr1_copier_tmo #(
    parameter int LIMIT = 255,
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [WIDTH-1:0] cnt;

    assign expired = inc && (cnt == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/scr1_dmem_copier.sv
// scr1_dmem_copier: single-channel word block copier driving the SCR1 data-memory requester interface
// Ports: cfg_* start/source/destination/length from the control front end; status_* busy, sticky done/err,
//        error code/address and words-written count; dmem_* request side of the data-memory interface.
module scr1_dmem_copier
    import scr1_copier_pkg::*;
#(
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [SCR1_DMEM_AWIDTH-1:0] cfg_src_addr,
    input  logic [SCR1_DMEM_AWIDTH-1:0] cfg_dst_addr,
    input  logic [LEN_WIDTH-1:0]        cfg_len,
    output logic                        status_busy,
    output logic                        status_done,
    output logic                        status_err,
    output type_scr1_copier_err_e       status_err_code,
    output logic [SCR1_DMEM_AWIDTH-1:0] status_err_addr,
    output logic [LEN_WIDTH-1:0]        status_cnt,
    output logic                        dmem_req,
    output type_scr1_mem_cmd_e          dmem_cmd,
    output type_scr1_mem_width_e        dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    input  logic                        dmem_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    input  type_scr1_mem_resp_e         dmem_resp
);

    localparam logic [SCR1_DMEM_AWIDTH-1:0] STRIDE = SCR1_DMEM_AWIDTH'(SCR1_COPIER_WORD_STRIDE);

    type_scr1_copier_state_e     state, state_next;
    logic [SCR1_DMEM_AWIDTH-1:0] src, dst;
    logic [LEN_WIDTH-1:0]        len;
    logic in_wait, resp_ok, resp_er, tmo_inc, tmo_exp, abort, last, misalign, accept;

    assign in_wait  = (state == SCR1_COPIER_RD_WAIT) || (state == SCR1_COPIER_WR_WAIT);
    assign resp_ok  = in_wait && (dmem_resp == SCR1_MEM_RESP_RDY_OK);
    assign resp_er  = in_wait && (dmem_resp == SCR1_MEM_RESP_RDY_ER);
    assign tmo_inc  = in_wait && (dmem_resp == SCR1_MEM_RESP_NOTRDY);
    assign abort    = resp_er || tmo_exp;
    assign last     = (status_cnt + LEN_WIDTH'(1)) == len;
    assign accept   = (state == SCR1_COPIER_IDLE) && cfg_start;
    // A zero-length request completes immediately, so alignment only matters when words will move.
    assign misalign = (cfg_len != '0) && ((cfg_src_addr[1:0] != 2'b00) || (cfg_dst_addr[1:0] != 2'b00));

    // Request and address decode straight from state so an async reset drops dmem_req at once.
    assign dmem_req    = (state == SCR1_COPIER_RD_REQ) || (state == SCR1_COPIER_WR_REQ);
    assign dmem_cmd    = ((state == SCR1_COPIER_WR_REQ) || (state == SCR1_COPIER_WR_WAIT)) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign dmem_width  = SCR1_MEM_WIDTH_WORD;
    assign dmem_addr   = (state == SCR1_COPIER_IDLE) ? '0 : (dmem_cmd == SCR1_MEM_CMD_WR) ? dst : src;
    assign status_busy = state != SCR1_COPIER_IDLE;

    scr1_copier_tmo #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TMO_WIDTH)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (!in_wait),
        .inc     (tmo_inc),
        .expired (tmo_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= SCR1_COPIER_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SCR1_COPIER_IDLE:    state_next = (accept && cfg_len != '0 && !misalign) ? SCR1_COPIER_RD_REQ : SCR1_COPIER_IDLE;
            SCR1_COPIER_RD_REQ:  state_next = dmem_req_ack ? SCR1_COPIER_RD_WAIT : SCR1_COPIER_RD_REQ;
            SCR1_COPIER_WR_REQ:  state_next = dmem_req_ack ? SCR1_COPIER_WR_WAIT : SCR1_COPIER_WR_REQ;
            SCR1_COPIER_RD_WAIT: state_next = abort ? SCR1_COPIER_IDLE : resp_ok ? SCR1_COPIER_WR_REQ : SCR1_COPIER_RD_WAIT;
            SCR1_COPIER_WR_WAIT: state_next = (abort || (resp_ok && last)) ? SCR1_COPIER_IDLE :
                                              resp_ok ? SCR1_COPIER_RD_REQ : SCR1_COPIER_WR_WAIT;
            default:             state_next = SCR1_COPIER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src             <= '0;
            dst             <= '0;
            len             <= '0;
            dmem_wdata      <= '0;
            status_done     <= 1'b0;
            status_err      <= 1'b0;
            status_err_code <= SCR1_COPIER_ERR_NONE;
            status_err_addr <= '0;
            status_cnt      <= '0;
        end else begin
            if (accept) begin
                src             <= cfg_src_addr;
                dst             <= cfg_dst_addr;
                len             <= cfg_len;
                status_cnt      <= '0;
                status_done     <= cfg_len == '0;
                status_err      <= misalign;
                status_err_code <= misalign ? SCR1_COPIER_ERR_MISALIGN : SCR1_COPIER_ERR_NONE;
                if (misalign)
                    status_err_addr <= (cfg_src_addr[1:0] != 2'b00) ? cfg_src_addr : cfg_dst_addr;
            end
            if (resp_ok && state == SCR1_COPIER_RD_WAIT)
                dmem_wdata <= dmem_rdata;
            if (resp_ok && state == SCR1_COPIER_WR_WAIT) begin
                status_cnt <= status_cnt + LEN_WIDTH'(1);
                src        <= src + STRIDE;
                dst        <= dst + STRIDE;
                if (last)
                    status_done <= 1'b1;
            end
            if (abort) begin
                status_err      <= 1'b1;
                status_err_code <= resp_er ? SCR1_COPIER_ERR_BUSERR : SCR1_COPIER_ERR_TIMEOUT;
                status_err_addr <= dmem_addr;
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_copier.sv
// tb_scr1_dmem_copier: table-driven and randomized checks of the copier against a word-level copy model
module tb_scr1_dmem_copier;
    import scr1_copier_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  cfg_start = 1'b0;
    logic [31:0]           cfg_src_addr = '0, cfg_dst_addr = '0;
    logic [15:0]           cfg_len = '0;
    logic                  status_busy, status_done, status_err;
    type_scr1_copier_err_e status_err_code;
    logic [31:0]           status_err_addr;
    logic [15:0]           status_cnt;
    logic                  dmem_req;
    type_scr1_mem_cmd_e    dmem_cmd;
    type_scr1_mem_width_e  dmem_width;
    logic [31:0]           dmem_addr, dmem_wdata;
    logic                  dmem_req_ack;
    logic [31:0]           dmem_rdata;
    type_scr1_mem_resp_e   dmem_resp;

    scr1_dmem_copier #(
        .LEN_WIDTH      (16),
        .TIMEOUT_CYCLES (TMO),
        .TMO_WIDTH      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_start       (cfg_start),
        .cfg_src_addr    (cfg_src_addr),
        .cfg_dst_addr    (cfg_dst_addr),
        .cfg_len         (cfg_len),
        .status_busy     (status_busy),
        .status_done     (status_done),
        .status_err      (status_err),
        .status_err_code (status_err_code),
        .status_err_addr (status_err_addr),
        .status_cnt      (status_cnt),
        .dmem_req        (dmem_req),
        .dmem_cmd        (dmem_cmd),
        .dmem_width      (dmem_width),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_req_ack    (dmem_req_ack),
        .dmem_rdata      (dmem_rdata),
        .dmem_resp       (dmem_resp)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [31:0] src, dst;
        logic [15:0] len;
        int          stall;
        bit          err_en;
        logic [31:0] err_at;
        bit          hang;
        bit          exp_done, exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_eaddr;
        logic [15:0] exp_cnt;
        int          exp_cyc;
    } vec_t;

    txn_t        log_q[$], exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          stall_n = 0, waited = 0;
    bit          err_en = 0, hang = 0, pend = 0;
    logic [31:0] err_at = '0;
    txn_t        pt;
    int          total = 0, bad = 0;
    vec_t        tbl [11];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: acks after stall_n waiting cycles, answers one cycle after the accept.
    initial begin
        dmem_req_ack = 1'b0;
        dmem_resp    = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata   = '0;
        forever begin
            @(posedge clk);
            #1;
            dmem_req_ack = 1'b0;
            dmem_resp    = SCR1_MEM_RESP_NOTRDY;
            if (rst) begin
                pend   = 0;
                waited = 0;
            end else begin
                if (pend && !hang) begin
                    if (pt.wr && err_en && pt.addr == err_at)
                        dmem_resp = SCR1_MEM_RESP_RDY_ER;
                    else begin
                        dmem_resp = SCR1_MEM_RESP_RDY_OK;
                        if (pt.wr) mem[pt.addr] = pt.data;
                        else dmem_rdata = mem_rd(pt.addr);
                    end
                end
                pend = 0;
                if (dmem_req) begin
                    if (waited < stall_n) waited++;
                    else begin
                        dmem_req_ack = 1'b1;
                        waited       = 0;
                        pend         = 1;
                        pt.wr        = dmem_cmd == SCR1_MEM_CMD_WR;
                        pt.addr      = dmem_addr;
                        pt.data      = pt.wr ? dmem_wdata : 32'h0;
                        log_q.push_back(pt);
                    end
                end
            end
        end
    end

    // Word-by-word copy model: expected bus log, status and completion cycle.
    function automatic void model(input vec_t v, output vec_t e);
        logic [31:0] ov [logic [31:0]];
        logic [31:0] s, d, w;
        txn_t t;
        e = v;
        exp_q.delete();
        e.exp_done = 0; e.exp_err = 0; e.exp_code = 0; e.exp_eaddr = 0; e.exp_cnt = 0; e.exp_cyc = 1;
        if (v.len == 0) begin
            e.exp_done = 1;
            return;
        end
        if (v.src[1:0] != 0 || v.dst[1:0] != 0) begin
            e.exp_err = 1; e.exp_code = 3;
            e.exp_eaddr = (v.src[1:0] != 0) ? v.src : v.dst;
            return;
        end
        for (int i = 0; i < int'(v.len); i++) begin
            s = v.src + 32'(4 * i);
            d = v.dst + 32'(4 * i);
            w = ov.exists(s) ? ov[s] : mem_rd(s);
            t.wr = 0; t.addr = s; t.data = 0;
            exp_q.push_back(t);
            if (v.hang) begin
                e.exp_err = 1; e.exp_code = 2; e.exp_eaddr = s;
                e.exp_cyc = 1 + v.stall + TMO + 1;
                return;
            end
            t.wr = 1; t.addr = d; t.data = w;
            exp_q.push_back(t);
            e.exp_cyc = (i + 1) * (4 + 2 * v.stall) + 1;
            if (v.err_en && d == v.err_at) begin
                e.exp_err = 1; e.exp_code = 1; e.exp_eaddr = d;
                return;
            end
            ov[d] = w;
            e.exp_cnt = 16'(i + 1);
        end
        e.exp_done = 1;
    endfunction

    task automatic fill(input vec_t v, input bit rnd);
        for (int i = 0; i < int'(v.len); i++)
            mem[v.src + 32'(4 * i)] = rnd ? $urandom : 32'hA1 + 32'(i) * 32'h11;
    endtask

    task automatic run(input vec_t v, input string tag, input bit poke);
        vec_t e;
        int   cyc;
        stall_n = v.stall; err_en = v.err_en; err_at = v.err_at; hang = v.hang;
        model(v, e);
        log_q.delete();
        @(negedge clk);
        cfg_src_addr = v.src; cfg_dst_addr = v.dst; cfg_len = v.len; cfg_start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            cfg_start = poke && cyc == 2;
            if (cfg_start) begin
                cfg_src_addr = 32'h700; cfg_dst_addr = 32'h7F3; cfg_len = 16'd1;
            end
        end while (!(status_done || status_err) && cyc < 400);
        cfg_start = 1'b0;
        chk({tag, ".ended"}, 32'(status_done | status_err), 32'd1);
        chk({tag, ".cycles"}, cyc, v.exp_cyc);
        chk({tag, ".done"}, 32'(status_done), 32'(v.exp_done));
        chk({tag, ".err"}, 32'(status_err), 32'(v.exp_err));
        chk({tag, ".code"}, 32'(status_err_code), 32'(v.exp_code));
        if (v.exp_err) chk({tag, ".err_addr"}, status_err_addr, v.exp_eaddr);
        chk({tag, ".cnt"}, 32'(status_cnt), 32'(v.exp_cnt));
        repeat (4) @(negedge clk);
        chk({tag, ".busy"}, 32'(status_busy), 32'd0);
        chk({tag, ".req"}, 32'(dmem_req), 32'd0);
        chk({tag, ".n_txn"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s.txn%0d.wr", tag, i), 32'(log_q[i].wr), 32'(exp_q[i].wr));
            chk($sformatf("%s.txn%0d.addr", tag, i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s.txn%0d.data", tag, i), log_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            src            dst            len    st er err_at      hg dn er cd eaddr          cnt    cyc
        tbl[0]  = '{32'h100,      32'h200,      16'd3, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd3, 13};
        tbl[1]  = '{32'h100,      32'h200,      16'd0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd0, 1};
        tbl[2]  = '{32'h102,      32'h200,      16'd1, 0, 0, 32'h0,     0, 0, 1, 3, 32'h102,    16'd0, 1};
        tbl[3]  = '{32'h100,      32'h203,      16'd2, 0, 0, 32'h0,     0, 0, 1, 3, 32'h203,    16'd0, 1};
        tbl[4]  = '{32'h400,      32'h200,      16'd4, 0, 1, 32'h204,   0, 0, 1, 1, 32'h204,    16'd1, 9};
        tbl[5]  = '{32'hFFFFFFF8, 32'h10,       16'd3, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd3, 13};
        tbl[6]  = '{32'h20,       32'hFFFFFFFC, 16'd2, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd2, 9};
        tbl[7]  = '{32'h3,        32'h5,        16'd0, 0, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd0, 1};
        tbl[8]  = '{32'h300,      32'h380,      16'd2, 2, 0, 32'h0,     0, 1, 0, 0, 32'h0,      16'd2, 17};
        tbl[9]  = '{32'h800,      32'h900,      16'd1, 0, 0, 32'h0,     1, 0, 1, 2, 32'h800,    16'd0, 10};
        tbl[10] = '{32'h440,      32'h540,      16'd2, 1, 1, 32'h540,   0, 0, 1, 1, 32'h540,    16'd0, 7};

        repeat (3) @(negedge clk);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
        chk("rst.width", 32'(dmem_width), 32'(SCR1_MEM_WIDTH_WORD));
        chk("rst.addr", dmem_addr, 32'h0);
        chk("rst.wdata", dmem_wdata, 32'h0);
        chk("rst.busy", 32'(status_busy), 32'd0);
        chk("rst.done", 32'(status_done), 32'd0);
        chk("rst.err", 32'(status_err), 32'd0);
        chk("rst.code", 32'(status_err_code), 32'd0);
        chk("rst.err_addr", status_err_addr, 32'h0);
        chk("rst.cnt", 32'(status_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            fill(tbl[i], 0);
            run(tbl[i], $sformatf("vec%0d", i), i == 0);
        end

        // Acknowledge held off three cycles: request must stay stable for four.
        stall_n = 3; err_en = 0; hang = 0;
        @(negedge clk);
        cfg_src_addr = 32'h300; cfg_dst_addr = 32'h340; cfg_len = 16'd1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall.req%0d", i), 32'(dmem_req), 32'd1);
            chk($sformatf("stall.addr%0d", i), dmem_addr, 32'h300);
            chk($sformatf("stall.cmd%0d", i), 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
            @(negedge clk);
        end
        chk("stall.req_dropped", 32'(dmem_req), 32'd0);
        for (int i = 0; i < 60 && !status_done; i++) @(negedge clk);
        chk("stall.done", 32'(status_done), 32'd1);

        for (int n = 0; n < 25; n++) begin
            vec_t v, e;
            v.src = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            v.dst = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
            if ($urandom_range(0, 7) == 0) v.src[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) v.dst[1:0] = 2'($urandom_range(1, 3));
            v.len    = 16'($urandom_range(0, 6));
            v.stall  = $urandom_range(0, 2);
            v.hang   = 0;
            v.err_en = (v.len != 0) && ($urandom_range(0, 3) == 0);
            v.err_at = v.err_en ? v.dst + 32'($urandom_range(0, int'(v.len) - 1)) * 4 : 32'h0;
            fill(v, 1);
            model(v, e);
            run(e, $sformatf("rnd%0d", n), 0);
        end

        // Reset in the middle of a transfer.
        stall_n = 0; err_en = 0; hang = 0;
        mem[32'hA00] = 32'hDEADBEEF;
        @(negedge clk);
        cfg_src_addr = 32'hA00; cfg_dst_addr = 32'hB00; cfg_len = 16'd4; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst.pre_req", 32'(dmem_req), 32'd1);
        chk("midrst.pre_cnt", 32'(status_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.req", 32'(dmem_req), 32'd0);
        chk("midrst.busy", 32'(status_busy), 32'd0);
        chk("midrst.done", 32'(status_done), 32'd0);
        chk("midrst.err", 32'(status_err), 32'd0);
        chk("midrst.cnt", 32'(status_cnt), 32'd0);
        chk("midrst.addr", dmem_addr, 32'h0);
        chk("midrst.wdata", dmem_wdata, 32'h0);
        chk("midrst.cmd", 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
        @(negedge clk);
        rst = 1'b0;
        fill(tbl[0], 0);
        run(tbl[0], "post_rst", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_copier.md
Name: scr1_dmem_copier

Overview:
Single-channel block-copy initiator that drives the SCR1 data-memory interface from the requester side. It issues word reads and writes to memory-mapped responders such as the timer, TCM or interconnect ports. It copies `cfg_len` words from a source address to a destination address with at most one transaction outstanding. It reports completion, word count and errors (bus error, response timeout, misalignment) to a local control/status front end.

Parameters:
- LEN_WIDTH, 16, width of word-count input and progress counter
- TIMEOUT_CYCLES, 255, max cycles spent waiting for a response before aborting; must be ≥1
- TMO_WIDTH, 8, width of the timeout counter; must satisfy 2^TMO_WIDTH > TIMEOUT_CYCLES

Ports:
- clk  in  1  core clock; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse; ignored while busy
- cfg_src_addr  in  `SCR1_DMEM_AWIDTH  source byte address, sampled on accepted start
- cfg_dst_addr  in  `SCR1_DMEM_AWIDTH  destination byte address, sampled on accepted start
- cfg_len  in  LEN_WIDTH  number of 32-bit words, sampled on accepted start
- status_busy  out  1  transfer in progress
- status_done  out  1  sticky; set on successful completion, cleared by next accepted start
- status_err  out  1  sticky; set on abort, cleared by next accepted start
- status_err_code  out  2  type_scr1_copier_err_e
- status_err_addr  out  `SCR1_DMEM_AWIDTH  address of the failing access
- status_cnt  out  LEN_WIDTH  words fully written
- dmem_req  out  1  request valid
- dmem_cmd  out  type_scr1_mem_cmd_e  RD/WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  `SCR1_DMEM_AWIDTH  request address
- dmem_wdata  out  `SCR1_DMEM_DWIDTH  write data
- dmem_req_ack  in  1  responder accepts the request this cycle
- dmem_rdata  in  `SCR1_DMEM_DWIDTH  read data, valid with RDY_OK
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- Reset values:
  - dmem_req=0, dmem_cmd=RD, dmem_width=WORD, dmem_addr=0, dmem_wdata=0
  - all status outputs 0
  - state IDLE
  - reset mid-transfer drops dmem_req immediately (asynchronous); no completion or error is flagged.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - On cfg_start, clear done, err, err_code and cnt, then latch src, dst and len.
  - If len==0: set done, stay IDLE, no bus traffic.
  - Else if src[1:0]≠0: err MISALIGN, err_addr=src. Else if dst[1:0]≠0: err MISALIGN, err_addr=dst. Neither case issues bus traffic.
  - Otherwise set busy and go to RD_REQ.
- RD_REQ / WR_REQ:
  - Hold dmem_req=1 with cmd, addr and wdata stable until dmem_req_ack=1.
  - In the ack cycle the request is accepted. Next cycle: req=0, move to the matching *_WAIT, timeout counter cleared.
- RD_WAIT / WR_WAIT:
  - dmem_req=0; the counter increments each cycle while resp==NOTRDY.
  - RDY_OK in RD_WAIT: capture rdata into wdata, go to WR_REQ.
  - RDY_OK in WR_WAIT: cnt+1, src+4, dst+4. If cnt+1==len: set done, clear busy, go to IDLE. Else go to RD_REQ.
  - RDY_ER: err BUSERR, err_addr = current address, clear busy, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES with resp still NOTRDY: err TIMEOUT, same abort.
  - Any resp value other than NOTRDY seen in a non-WAIT state is ignored.
- Address arithmetic: modulo 2^AWIDTH; wrap past 0xFFFF_FFFC continues at 0x0 without error.
- Throughput with a zero-wait responder (ack=1, resp one cycle after accept): 4 cycles per word. done is set the cycle after the last write's RDY_OK.
- cfg_start while busy: ignored, with no effect on the latched configuration.
- Only one transaction is ever outstanding; a new request is never raised while in a WAIT state.

Decomposition:
- Package scr1_copier_pkg holds:
  - type_scr1_copier_state_e (5 states)
  - type_scr1_copier_err_e: NONE=0, BUSERR=1, TIMEOUT=2, MISALIGN=3
  - localparam SCR1_COPIER_WORD_STRIDE=4
- Memory types come from scr1_memif.svh.
- One sub-module is natural: scr1_copier_tmo, a clearable saturating wait counter with an expiry flag.

Test Plan:
- Zero-wait responder; src=0x100, dst=0x200, len=3, memory 0x100..0x108 = 0xA1,0xB2,0xC3 -> reads 0x100/104/108, writes 0x200/204/208 with the same data; done=1 exactly 13 cycles after the start pulse; cnt=3; err=0.
- len=0 -> done=1 next cycle, dmem_req never asserted, busy stays 0.
- src=0x102, len=1 -> err=1, code=MISALIGN, err_addr=0x102, no request.
- Responder returns RDY_ER on the write to 0x204, len=4 -> err=BUSERR, err_addr=0x204, cnt=1, no further requests.
- TIMEOUT_CYCLES=8, responder never responds to the first read -> err=TIMEOUT after 8 WAIT cycles, dmem_req=0, busy=0.
- Stall and robustness:
  - ack held low 3 cycles -> req, addr and cmd stay stable for 4 cycles.
  - cfg_start while busy is ignored.
  - rst asserted mid-transfer -> req drops combinationally; all outputs return to reset values.
